// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int ADDRESS_SIZE = 11,
  parameter int WORD_SIZE    = 64
);
  logic                    reqValid;
  logic                    reqReady;
  logic                    isReading;
  logic [ADDRESS_SIZE-1:0] address;
  logic [WORD_SIZE-1:0]    dataIn;
  logic                    respValid;
  logic                    respReady;
  logic [WORD_SIZE-1:0]    dataOut;
  logic                    respError;

  modport master (
    output reqValid, isReading, address, dataIn, respReady,
    input  reqReady, respValid, dataOut, respError
  );

  modport slave (
    input  reqValid, isReading, address, dataIn, respReady,
    output reqReady, respValid, dataOut, respError
  );
endinterface

// File: rtl/mem_responder.sv
// Stalling word memory with a request/response handshake and LATENCY wait states.
// Optional per-word even parity is enabled by defining MEM_RESPONDER_PARITY_EN.
module mem_responder #(
  parameter int ADDRESS_SIZE = 11,
  parameter int WORD_SIZE    = 64,
  parameter int LATENCY      = 2,
  parameter int DEPTH        = 2**(ADDRESS_SIZE-2)
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MEM_RESPONDER_PARITY_EN
  input  logic            injectParityErr,
`endif
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         IDX_W = ADDRESS_SIZE - 2;
  localparam logic [3:0] LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t                  r_state;
  logic [3:0]              r_count;
  logic                    r_isReading;
  logic [ADDRESS_SIZE-1:0] r_address;
  logic [WORD_SIZE-1:0]    r_dataIn;
  logic                    r_reqReady;
  logic                    r_respValid;
  logic [WORD_SIZE-1:0]    r_dataOut;
  logic                    r_respError;
  logic [WORD_SIZE-1:0]    r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_commit;
  logic                    w_isReading;
  logic [ADDRESS_SIZE-1:0] w_address;
  logic [WORD_SIZE-1:0]    w_dataIn;
  logic [IDX_W-1:0]        w_index;
  logic                    w_misaligned;
  logic                    w_memWrite;
  logic [WORD_SIZE-1:0]    w_readWord;
  logic                    w_readBad;
  logic [WORD_SIZE-1:0]    w_respData;
  logic                    w_respError;

  // With zero latency the commit happens on the accept edge, so use live inputs in IDLE.
  assign w_accept     = (r_state == IDLE) && bus.reqValid;
  assign w_commit     = ((r_state == WAIT) && (r_count == 4'd0)) || (w_accept && (LATENCY == 0));
  assign w_isReading  = (r_state == IDLE) ? bus.isReading : r_isReading;
  assign w_address    = (r_state == IDLE) ? bus.address   : r_address;
  assign w_dataIn     = (r_state == IDLE) ? bus.dataIn    : r_dataIn;
  assign w_index      = w_address[ADDRESS_SIZE-1:2];
  assign w_misaligned = |w_address[1:0];
  assign w_memWrite   = w_commit && !w_isReading && !w_misaligned;
  assign w_readWord   = r_mem[w_index];

`ifdef MEM_RESPONDER_PARITY_EN
  logic r_parity [DEPTH];
  logic r_inject;
  logic w_inject;

  assign w_inject  = (r_state == IDLE) ? injectParityErr : r_inject;
  assign w_readBad = (^w_readWord) != r_parity[w_index];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inject <= 1'b0;
    end else begin
      if (w_accept) begin
        r_inject <= injectParityErr;
      end
      if (w_memWrite) begin
        r_parity[w_index] <= (^w_dataIn) ^ w_inject;
      end
    end
  end
`else
  assign w_readBad = 1'b0;
`endif

  assign w_respData  = (w_isReading && !w_misaligned) ? w_readWord : '0;
  assign w_respError = w_misaligned || (w_isReading && w_readBad);

  // Storage is never cleared by reset; a write aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (rst_n && w_memWrite) begin
      r_mem[w_index] <= w_dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_dataOut   <= '0;
      r_respError <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.reqValid) begin
            r_isReading <= bus.isReading;
            r_address   <= bus.address;
            r_dataIn    <= bus.dataIn;
            r_reqReady  <= 1'b0;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_dataOut   <= w_respData;
              r_respError <= w_respError;
            end else begin
              r_count <= LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_dataOut   <= w_respData;
            r_respError <= w_respError;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          if (bus.respReady) begin
            r_state     <= IDLE;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_dataOut   <= '0;
            r_respError <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.reqReady  = r_reqReady;
  assign bus.respValid = r_respValid;
  assign bus.dataOut   = r_dataOut;
  assign bus.respError = r_respError;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder at LATENCY=2 and LATENCY=0.
// Connects injectParityErr only when MEM_RESPONDER_PARITY_EN is defined.
module tb_mem_responder;

  localparam int AW = 11;
  localparam int WW = 64;

  typedef struct {
    logic [WW-1:0] data;
    logic          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) bus2 ();
  mem_responder_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) bus0 ();

  mem_responder #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .LATENCY(2)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MEM_RESPONDER_PARITY_EN
    .injectParityErr(1'b0),
`endif
    .bus(bus2)
  );

  mem_responder #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .LATENCY(0)) dut0 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MEM_RESPONDER_PARITY_EN
    .injectParityErr(1'b0),
`endif
    .bus(bus0)
  );

  function automatic logic rdReady(input int lat);
    return (lat == 0) ? bus0.reqReady : bus2.reqReady;
  endfunction

  function automatic logic rdValid(input int lat);
    return (lat == 0) ? bus0.respValid : bus2.respValid;
  endfunction

  function automatic logic [WW-1:0] rdData(input int lat);
    return (lat == 0) ? bus0.dataOut : bus2.dataOut;
  endfunction

  function automatic logic rdErr(input int lat);
    return (lat == 0) ? bus0.respError : bus2.respError;
  endfunction

  task automatic drive(input int lat, input logic v, input logic rd,
                       input logic [AW-1:0] a, input logic [WW-1:0] d);
    if (lat == 0) begin
      bus0.reqValid = v; bus0.isReading = rd; bus0.address = a; bus0.dataIn = d;
    end else begin
      bus2.reqValid = v; bus2.isReading = rd; bus2.address = a; bus2.dataIn = d;
    end
  endtask

  task automatic setRespReady(input int lat, input logic r);
    if (lat == 0) bus0.respReady = r;
    else          bus2.respReady = r;
  endtask

  task automatic checkOutput(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Accepted inputs are scrambled right after the accept edge, so only the sampled values may matter.
  task automatic applyStimulus(input int lat, input logic rd, input logic [AW-1:0] addr,
                               input logic [WW-1:0] data, input logic [WW-1:0] expData,
                               input logic expErr, input int hold);
    exp_t e;
    int   edges;
    sb.push_back('{data: expData, err: expErr});
    @(negedge clk);
    checkOutput("reqReadyIdle", rdReady(lat), 1);
    drive(lat, 1'b1, rd, addr, data);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drive(lat, 1'b0, ~rd, ~addr, ~data);
    while (!rdValid(lat) && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("latencyEdges", edges, lat + 1);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      drive(lat, 1'b1, 1'b0, 11'h010, 64'hBAD0BAD0BAD0BAD0);
      checkOutput("holdValid", rdValid(lat), 1);
      checkOutput("holdData", rdData(lat), e.data);
      @(negedge clk);
    end
    drive(lat, 1'b0, 1'b0, '0, '0);
    checkOutput("respData", rdData(lat), e.data);
    checkOutput("respError", rdErr(lat), e.err);
    setRespReady(lat, 1'b1);
    @(negedge clk);
    setRespReady(lat, 1'b0);
    checkOutput("clearValid", rdValid(lat), 0);
    checkOutput("clearData", rdData(lat), 0);
    checkOutput("clearError", rdErr(lat), 0);
    checkOutput("readyAgain", rdReady(lat), 1);
  endtask

  initial begin
    drive(2, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b0, 1'b0, '0, '0);
    setRespReady(2, 1'b0);
    setRespReady(0, 1'b0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset state");
    checkOutput("rstReady2", rdReady(2), 1);
    checkOutput("rstValid2", rdValid(2), 0);
    checkOutput("rstData2", rdData(2), 0);
    checkOutput("rstError2", rdErr(2), 0);
    checkOutput("rstReady0", rdReady(0), 1);
    checkOutput("rstValid0", rdValid(0), 0);

    $display("[TB] LATENCY=2 write/read/backpressure/misaligned");
    applyStimulus(2, 1'b0, 11'h010, 64'h00000000DEADBEEF, 64'h0, 1'b0, 0);
    applyStimulus(2, 1'b1, 11'h010, 64'h0, 64'h00000000DEADBEEF, 1'b0, 5);
    applyStimulus(2, 1'b1, 11'h013, 64'h0, 64'h0, 1'b1, 0);
    applyStimulus(2, 1'b0, 11'h012, 64'h0123456789ABCDEF, 64'h0, 1'b1, 0);
    applyStimulus(2, 1'b1, 11'h010, 64'h0, 64'h00000000DEADBEEF, 1'b0, 0);

    $display("[TB] LATENCY=0 write/read");
    applyStimulus(0, 1'b0, 11'h7FC, 64'h1, 64'h0, 1'b0, 0);
    applyStimulus(0, 1'b1, 11'h7FC, 64'h0, 64'h1, 1'b0, 0);
    applyStimulus(0, 1'b0, 11'h000, 64'hA5A5A5A5FFFF0000, 64'h0, 1'b0, 1);
    applyStimulus(0, 1'b1, 11'h000, 64'h0, 64'hA5A5A5A5FFFF0000, 1'b0, 0);
    applyStimulus(0, 1'b1, 11'h7FD, 64'h0, 64'h0, 1'b1, 0);
    applyStimulus(0, 1'b1, 11'h7FC, 64'h0, 64'h1, 1'b0, 0);

    $display("[TB] reset in the middle of a LATENCY=2 write");
    applyStimulus(2, 1'b0, 11'h020, 64'h1111, 64'h0, 1'b0, 0);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 11'h020, 64'h55);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, '0, '0);
    checkOutput("midWaitBusy", rdReady(2), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abortReady", rdReady(2), 1);
    checkOutput("abortValid", rdValid(2), 0);
    repeat (3) @(negedge clk);
    checkOutput("abortStillIdle", rdValid(2), 0);
    applyStimulus(2, 1'b1, 11'h020, 64'h0, 64'h1111, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
